// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the serial-add sequencer and its shift registers.
package serial_add_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_SHIFT = 2'd1,
    SEQ_HOLD  = 2'd2
  } seq_state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register: LSB first, zero fill from the top.
module piso_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             serial_o
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= data_i;
    end else if (shift_i) begin
      sr_q <= {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  assign serial_o = sr_q[0];

endmodule

// File: rtl/serial_add_sequencer.sv
// Feeds two parallel operands LSB-first into an external 1-bit serial adder and
// collects its sum stream (plus final carry) into a parallel result.
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             x_o,
  output logic             y_o,
  output logic             adder_rst_o,
  input  logic             s_in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   sum_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH);

  seq_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   sum_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             adder_rst_q;
  logic             busy_q;

  logic accept;
  logic shift_en;

  assign accept   = in_valid_i && in_ready_q && (state_q == SEQ_IDLE);
  assign shift_en = (state_q == SEQ_SHIFT);

  piso_shift_reg #(
    .WIDTH (WIDTH)
  ) u_a_sr (
    .clk      (clk),
    .reset    (reset),
    .load_i   (accept),
    .shift_i  (shift_en),
    .data_i   (op_a_i),
    .serial_o (x_o)
  );

  piso_shift_reg #(
    .WIDTH (WIDTH)
  ) u_b_sr (
    .clk      (clk),
    .reset    (reset),
    .load_i   (accept),
    .shift_i  (shift_en),
    .data_i   (op_b_i),
    .serial_o (y_o)
  );

  // The final SHIFT cycle has x=y=0, so the bit captured there is the carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEQ_IDLE;
      cnt_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      adder_rst_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          if (accept) begin
            state_q     <= SEQ_SHIFT;
            cnt_q       <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b0;
            adder_rst_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        SEQ_SHIFT: begin
          sum_q <= {s_in_i, sum_q[WIDTH:1]};
          if (cnt_q == CntLast) begin
            state_q     <= SEQ_HOLD;
            out_valid_q <= 1'b1;
            adder_rst_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SEQ_HOLD: begin
          if (out_ready_i) begin
            state_q     <= SEQ_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= SEQ_IDLE;
          cnt_q       <= '0;
          sum_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          adder_rst_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign adder_rst_o = adder_rst_q;
  assign busy_o      = busy_q;
  assign sum_o       = sum_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench: sequencer plus a behavioural serial full-adder stage.
module tb_serial_add_sequencer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         x, y, adder_rst, s_in;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W:0]   sum;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_add_sequencer #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .x_o         (x),
    .y_o         (y),
    .adder_rst_o (adder_rst),
    .s_in_i      (s_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .busy_o      (busy)
  );

  // Stand-in for the hw1p1 stage: combinational sum, registered carry.
  logic carry_q;
  always_ff @(posedge clk) begin
    if (adder_rst) carry_q <= 1'b0;
    else           carry_q <= (x & y) | (x & carry_q) | (y & carry_q);
  end
  assign s_in = x ^ y ^ carry_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction; hold>0 keeps out_ready low for that many HOLD cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        input bit junk, output logic [W:0] got);
    int guard = 0;
    int lat = 0;
    logic [W:0] xs = '0;
    logic [W:0] ys = '0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check_eq("in_ready_wait", 32'(in_ready), 32'd1);
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (junk) begin
        op_a = W'($urandom);
        op_b = W'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        lat = k;
        break;
      end
      if (k <= W + 1) begin
        xs[k-1] = x;
        ys[k-1] = y;
      end
    end
    in_valid = 1'b0;
    got = sum;
    check_eq("latency", 32'(lat), 32'(W + 2));
    check_eq("x_stream", 32'(xs), 32'({1'b0, a}));
    check_eq("y_stream", 32'(ys), 32'({1'b0, b}));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_stable", 32'({out_valid, in_ready, sum}), 32'({1'b1, 1'b0, got}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("idle_after", 32'({out_valid, in_ready, busy, adder_rst}), 32'b0101);
  endtask

  initial begin
    logic [W:0] got;
    logic [W:0] got2;
    logic [W-1:0] ra, rb;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("reset_state",
             32'({in_ready, out_valid, x, y, adder_rst, busy}), 32'b100010);
    check_eq("reset_sum", 32'(sum), 32'd0);

    run_op(8'h05, 8'h03, 0, 1'b0, got);
    check_eq("t1_sum", 32'(got), 32'h008);

    run_op(8'hFF, 8'h01, 0, 1'b0, got);
    check_eq("t2_sum", 32'(got), 32'h100);

    run_op(8'hFF, 8'hFF, 0, 1'b0, got);
    run_op(8'h00, 8'h00, 0, 1'b0, got2);
    check_eq("t3_sum_a", 32'(got), 32'h1FE);
    check_eq("t3_sum_b", 32'(got2), 32'h000);

    run_op(8'h3C, 8'h5A, 5, 1'b0, got);
    check_eq("t4_sum", 32'(got), 32'h096);

    run_op(8'hA7, 8'h6E, 0, 1'b1, got);
    check_eq("t5_sum", 32'(got), 32'h115);

    // Abort during the 4th SHIFT cycle.
    op_a = 8'hC3;
    op_b = 8'h99;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t6_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("t6_after_reset",
             32'({in_ready, out_valid, adder_rst, busy}), 32'b1010);
    run_op(8'h10, 8'h20, 0, 1'b0, got);
    check_eq("t6_sum", 32'(got), 32'h030);

    // Reset and in_valid together: nothing is accepted.
    reset = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("reset_beats_valid", 32'({in_ready, busy}), 32'b10);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), got);
      check_eq("rand_sum", 32'(got), 32'({1'b0, ra} + {1'b0, rb}));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
